// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment reader: active-low glyph patterns
// (index 0 = segment a ... index 6 = segment g) and the filter state encoding.
package seg7_pkg;

  localparam int unsigned CNT_W = 8;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [0:6] SEG_A     = 7'b0001000;
  localparam logic [0:6] SEG_B     = 7'b1100000;
  localparam logic [0:6] SEG_C     = 7'b0110001;
  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_F     = 7'b0111000;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational glyph lookup: active-low segment pattern to value/blank/legal.
// Define SEG7_READER_HEX_EN to also accept the hex glyphs A..F as 10..15.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [0:6] seg,
  output logic [3:0] value,
  output logic       is_blank,
  output logic       is_legal
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    value    = 4'd0;
    is_blank = 1'b0;
    is_legal = 1'b1;
    case (seg)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
`ifdef SEG7_READER_HEX_EN
      SEG_A:     value = 4'd10;
      SEG_B:     value = 4'd11;
      SEG_C:     value = 4'd12;
      SEG_D:     value = 4'd13;
      SEG_E:     value = 4'd14;
      SEG_F:     value = 4'd15;
`endif
      default:   is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Debounces an active-low seven-segment bus, decodes stable glyphs and hands
// them to a consumer through a one-entry valid/ready buffer. Honours SEG7_READER_HEX_EN.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4  // legal range 2..255
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [0:6] seg_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 2);

  logic [0:6]       sample_q, sample_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [0:6]       committed_q, committed_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             overrun_q, overrun_d;

  logic [3:0] lut_value;
  logic       lut_blank;
  logic       lut_legal;
  logic       accept;
  logic       load;
  logic       transfer;

  // On the accept edge seg_in equals the sample, so decoding the sample is exact.
  seg7_to_bcd u_lut (
    .seg      (sample_q),
    .value    (lut_value),
    .is_blank (lut_blank),
    .is_legal (lut_legal)
  );

  // Stability filter and state machine.
  always_comb begin
    sample_d = sample_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    accept   = 1'b0;
    if (seg_in != sample_q) begin
      sample_d = seg_in;
      cnt_d    = '0;
      state_d  = SETTLE;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (state_q == SETTLE && cnt_q == CNT_ACCEPT) begin
        state_d = LOCKED;
        accept  = 1'b1;
      end
    end
  end

  // Commit, classify and drive the output buffer.
  always_comb begin
    committed_d = committed_q;
    digit_d     = digit_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    overrun_d   = 1'b0;
    load        = 1'b0;
    transfer    = valid_q && digit_ready;

    // Re-accepting the pattern already committed must stay silent.
    if (accept && sample_q != committed_q) begin
      committed_d = sample_q;
      if (!lut_legal)      err_d = 1'b1;
      else if (!lut_blank) load  = 1'b1;
    end

    if (load) begin
      digit_d   = lut_value;
      valid_d   = 1'b1;
      overrun_d = valid_q && !digit_ready;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sample_q    <= SEG_BLANK;
      cnt_q       <= '0;
      state_q     <= SETTLE;
      committed_q <= SEG_BLANK;
      digit_q     <= 4'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      committed_q <= committed_d;
      digit_q     <= digit_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign err         = err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios plus randomized
// patterns against a run-length reference model. Honours SEG7_READER_HEX_EN.
module tb_seg7_reader;

  localparam int STABLE = 4;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
`ifdef SEG7_READER_HEX_EN
  localparam int N_LEGAL = 16;
`else
  localparam int N_LEGAL = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [0:6] seg_in = 7'b1111111;
  logic [3:0] digit;
  logic       digit_valid;
  logic       digit_ready = 1'b0;
  logic       err;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int ov_seen = 0;
  int xfer7 = 0;

  // Reference model state: current run of identical samples and its length.
  logic [6:0] m_pat;
  int         m_len;
  logic [6:0] m_com;
  logic [3:0] m_digit;
  logic       m_valid;
  logic       m_err;
  logic       m_ov;

  seg7_reader #(.STABLE_CYCLES(STABLE)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .digit       (digit),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .err         (err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] p, output bit legal,
                                     output bit blank, output logic [3:0] val);
    blank = (p == BLANK);
    legal = blank;
    val   = 4'd0;
    for (int i = 0; i < N_LEGAL; i++) begin
      if (GLYPHS[i] == p) begin
        legal = 1'b1;
        val   = 4'(i);
      end
    end
  endfunction

  // A pattern is accepted on the edge where it has been seen STABLE times in a row.
  task automatic model_edge(input logic [6:0] seg, input logic rdy, input logic rst);
    bit         legal, blank, load;
    logic [3:0] val;
    m_err = 1'b0;
    m_ov  = 1'b0;
    if (rst) begin
      m_pat = BLANK; m_len = 1; m_com = BLANK;
      m_digit = 4'd0; m_valid = 1'b0;
      return;
    end
    if (seg == m_pat) m_len++;
    else begin
      m_pat = seg;
      m_len = 1;
    end
    load = 1'b0;
    if (m_len == STABLE && m_pat != m_com) begin
      m_com = m_pat;
      ref_decode(m_pat, legal, blank, val);
      if (!legal) m_err = 1'b1;
      else if (!blank) load = 1'b1;
    end
    if (load) begin
      m_ov    = m_valid && !rdy;
      m_digit = val;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic [6:0] seg, input logic rdy, input logic rst);
    seg_in      = seg;
    digit_ready = rdy;
    reset       = rst;
    if (!rst && digit_valid === 1'b1 && rdy && digit === 4'd7) xfer7++;
    model_edge(seg, rdy, rst);
    @(posedge clk);
    #1;
    check("digit", digit, m_digit);
    check("digit_valid", digit_valid, m_valid);
    check("err", err, m_err);
    check("overrun", overrun, m_ov);
    if (err === 1'b1) err_seen++;
    if (overrun === 1'b1) ov_seen++;
  endtask

  task automatic hold(input logic [6:0] seg, input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(seg, rdy, 1'b0);
  endtask

  initial begin
    // Reset state.
    step(BLANK, 1'b0, 1'b1);
    step(BLANK, 1'b0, 1'b1);
    check("rst_valid", digit_valid, 1'b0);
    check("rst_digit", digit, 4'd0);

    // Blank held after reset stays silent.
    err_seen = 0; ov_seen = 0;
    hold(BLANK, 1'b0, 6);
    check("blank_err", err_seen, 0);
    check("blank_valid", digit_valid, 1'b0);

    // Digit 2: load at edge k+3, consumed at edge k+5.
    hold(7'b0010010, 1'b0, 3);
    check("two_early_valid", digit_valid, 1'b0);
    step(7'b0010010, 1'b0, 1'b0);
    check("two_digit", digit, 4'd2);
    check("two_valid", digit_valid, 1'b1);
    step(7'b0010010, 1'b0, 1'b0);
    check("two_hold_valid", digit_valid, 1'b1);
    step(7'b0010010, 1'b1, 1'b0);
    check("two_xfer_valid", digit_valid, 1'b0);

    // Short glitch of '1' then blank: nothing reported.
    err_seen = 0; ov_seen = 0;
    hold(7'b1001111, 1'b0, 3);
    hold(BLANK, 1'b0, 5);
    check("glitch_valid", digit_valid, 1'b0);
    check("glitch_err", err_seen, 0);
    check("glitch_ov", ov_seen, 0);

    // 3 unconsumed, then 5 overwrites it.
    ov_seen = 0;
    hold(7'b0000110, 1'b0, 4);
    check("three_digit", digit, 4'd3);
    hold(7'b0100100, 1'b0, 4);
    check("five_digit", digit, 4'd5);
    check("five_valid", digit_valid, 1'b1);
    check("five_overrun", ov_seen, 1);
    step(7'b0100100, 1'b1, 1'b0);

    // Hex 'A' glyph.
    err_seen = 0;
    hold(7'b0001000, 1'b0, 4);
`ifdef SEG7_READER_HEX_EN
    check("hexA_digit", digit, 4'd10);
    check("hexA_valid", digit_valid, 1'b1);
    check("hexA_err", err_seen, 0);
`else
    check("hexA_err", err_seen, 1);
    check("hexA_valid", digit_valid, 1'b0);
`endif
    step(7'b0001000, 1'b1, 1'b0);

    // 7, blank, 7 again: two transfers; continued hold adds none.
    xfer7 = 0;
    hold(7'b0001111, 1'b1, 6);
    hold(BLANK, 1'b1, 5);
    hold(7'b0001111, 1'b1, 6);
    check("seven_twice", xfer7, 2);
    hold(7'b0001111, 1'b1, 20);
    check("seven_held", xfer7, 2);

    // Reset on the accept edge of 9, then 9 held four cycles.
    hold(7'b0000100, 1'b0, 3);
    step(7'b0000100, 1'b0, 1'b1);
    check("rst_acc_digit", digit, 4'd0);
    check("rst_acc_valid", digit_valid, 1'b0);
    check("rst_acc_err", err, 1'b0);
    check("rst_acc_ov", overrun, 1'b0);
    hold(7'b0000100, 1'b0, 4);
    check("nine_digit", digit, 4'd9);
    check("nine_valid", digit_valid, 1'b1);

    // Randomized patterns, hold lengths, readiness and occasional resets.
    for (int n = 0; n < 120; n++) begin
      logic [6:0] pat;
      int         len;
      case ($urandom_range(0, 3))
        0:       pat = 7'($urandom);
        1:       pat = BLANK;
        default: pat = GLYPHS[$urandom_range(0, 15)];
      endcase
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        step(pat, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
